// File: rtl/edge_replayer.sv
// Time-tagged event replayer: events queued as {time, data} are driven onto
// out_data when a free-running 8-bit window timebase matches the head's time.
module edge_replayer #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_time,
  input  logic [3:0] in_data,
  input  logic       start,
  output logic [3:0] out_data,
  output logic       busy,
  output logic       done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW + 1)'(DEPTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [7:0] at;
    logic [3:0] data;
  } event_t;

  event_t        r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  state_t        r_state;
  state_t        w_state_next;
  logic [7:0]    r_timebase;
  logic [7:0]    w_timebase_next;
  logic [3:0]    r_out_data;
  logic          r_done;

  event_t        w_head;
  logic          w_push;
  logic          w_pop;
  logic          w_last;

  // Full blocks writes even when a pop happens on the same edge.
  assign in_ready = (r_count != L_FULL);
  assign w_push   = in_valid && in_ready;
  assign w_head   = r_mem[r_rd_ptr];

  // Only entries already stored before this edge can match; a same-cycle
  // write lands at the tail and is invisible until a later cycle.
  assign w_pop  = (r_state == S_RUN) && (r_count != '0) && (w_head.at == r_timebase);
  assign w_last = (r_state == S_RUN) && (r_timebase == 8'hFF);

  assign busy     = (r_state == S_RUN);
  assign out_data = r_out_data;
  assign done     = r_done;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    w_state_next    = r_state;
    w_timebase_next = r_timebase;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next    = S_RUN;
          w_timebase_next = 8'd0;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_next    = S_IDLE;
          w_timebase_next = 8'd0;
        end else begin
          w_timebase_next = r_timebase + 8'd1;
        end
      end
      default: begin
        w_state_next    = S_IDLE;
        w_timebase_next = 8'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_timebase <= 8'd0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_timebase <= w_timebase_next;
      r_done     <= w_last;
    end
  end

  // NOTE: storage is not reset; validity is tracked by r_count, so the
  // array can map onto plain RAM/flops without a reset network.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{at: in_time, data: in_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data <= 4'd0;
    end else if (w_pop) begin
      r_out_data <= w_head.data;
    end
  end

endmodule
